// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared FSM encoding and width helper for the conv layer controller
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } conv_state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_group_mux.sv
// rtl/conv_group_mux.sv - selects one IFMAP_PAR-wide memory group onto the mult lanes
module conv_group_mux
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int INPUT_NUM_MEM = 10,
  parameter int IFMAP_PAR     = 2,
  localparam int NUM_GROUPS   = INPUT_NUM_MEM / IFMAP_PAR,
  localparam int GRP_W        = clog2_min1(NUM_GROUPS)
) (
  input  logic [GRP_W-1:0]                    group_sel,
  input  logic                                en,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] data_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     mux_all
);

  localparam int LANE_BITS = DATA_WIDTH * IFMAP_PAR;

  // Groups are contiguous in the memory bus, so lane j of group g is mem g*IFMAP_PAR+j.
  always_comb begin
    mux_all = '0;
    if (en) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (group_sel == GRP_W'(g)) begin
          mux_all = data_all[g*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/conv_layer_ctrl_gen.sv
// rtl/conv_layer_ctrl_gen.sv - conv layer sequencer: FSM, tap/group/pixel counters, enables, lane muxing
module conv_layer_ctrl_gen
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int INPUT_NUM_MEM = 10,
  parameter int IFMAP_PAR     = 2,
  parameter int CYC_PER_GROUP = 9,
  parameter int OUT_W         = 8,
  parameter int OUT_H         = 8,
  parameter int NUM_ONEMULT   = 1,
  parameter int PIPE_DELAY    = 4,
  localparam int NUM_GROUPS   = INPUT_NUM_MEM / IFMAP_PAR,
  localparam int CYC_PER_PIX  = NUM_GROUPS * CYC_PER_GROUP,
  localparam int NUM_PIX      = OUT_W * OUT_H * NUM_ONEMULT,
  localparam int CNT_W        = clog2_min1(CYC_PER_PIX),
  localparam int GRP_W        = clog2_min1(NUM_GROUPS)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                stall,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all,
  output logic                                mem_rden,
  output logic                                enable_addrger,
  output logic                                enable_mult,
  output logic                                accum_sload,
  output logic [CNT_W-1:0]                    count_sload,
  output logic [GRP_W-1:0]                    group_sel,
  output logic                                pix_done,
  output logic                                busy,
  output logic                                conv_done
);

  localparam int TAP_W = clog2_min1(CYC_PER_GROUP);
  localparam int PIX_W = clog2_min1(NUM_PIX);
  localparam int DLY_W = clog2_min1(PIPE_DELAY);

  if (INPUT_NUM_MEM % IFMAP_PAR != 0) begin : g_bad_par
    $error("INPUT_NUM_MEM must be a multiple of IFMAP_PAR");
  end

  conv_state_t      state, state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [TAP_W-1:0] tap_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [GRP_W-1:0] grp_cnt;
  logic [PIX_W-1:0] pix_cnt;

  logic dly_last, tap_last, grp_last, cyc_last, pix_last, in_run;

  assign dly_last = (dly_cnt == DLY_W'(PIPE_DELAY - 1));
  assign tap_last = (tap_cnt == TAP_W'(CYC_PER_GROUP - 1));
  assign grp_last = (grp_cnt == GRP_W'(NUM_GROUPS - 1));
  assign cyc_last = (cyc_cnt == CNT_W'(CYC_PER_PIX - 1));
  assign pix_last = (pix_cnt == PIX_W'(NUM_PIX - 1));
  assign in_run   = (state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort beats everything, including stall and a same-cycle start.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else if (!stall) begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_FILL;
        ST_FILL:  if (dly_last) state_nxt = ST_RUN;
        ST_RUN:   if (cyc_last && pix_last) state_nxt = ST_DRAIN;
        ST_DRAIN: if (dly_last) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dly_cnt <= '0;
      tap_cnt <= '0;
      cyc_cnt <= '0;
      grp_cnt <= '0;
      pix_cnt <= '0;
    end else if (abort) begin
      dly_cnt <= '0;
      tap_cnt <= '0;
      cyc_cnt <= '0;
      grp_cnt <= '0;
      pix_cnt <= '0;
    end else if (!stall) begin
      if (state == ST_FILL || state == ST_DRAIN) begin
        dly_cnt <= dly_last ? '0 : dly_cnt + 1'b1;
      end else begin
        dly_cnt <= '0;
      end
      // Group advance rides on the tap counter so no divide by CYC_PER_GROUP is needed.
      if (in_run) begin
        tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
        cyc_cnt <= cyc_last ? '0 : cyc_cnt + 1'b1;
        if (tap_last) grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
        if (cyc_last) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
      end else begin
        tap_cnt <= '0;
        cyc_cnt <= '0;
        grp_cnt <= '0;
        pix_cnt <= '0;
      end
    end
  end

  assign mem_rden       = (state == ST_FILL || in_run) && !stall;
  assign enable_addrger = mem_rden;
  assign enable_mult    = (in_run || state == ST_DRAIN) && !stall;
  assign accum_sload    = in_run && (cyc_cnt == '0);
  assign count_sload    = cyc_cnt;
  assign group_sel      = grp_cnt;
  assign pix_done       = in_run && cyc_last && !stall;
  assign busy           = (state != ST_IDLE);
  assign conv_done      = (state == ST_DONE) && !stall;

  conv_group_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .INPUT_NUM_MEM(INPUT_NUM_MEM),
    .IFMAP_PAR    (IFMAP_PAR)
  ) u_mux_a (
    .group_sel(grp_cnt),
    .en       (in_run),
    .data_all (in_feature_q_a_all),
    .mux_all  (in_feature_q_a_mux_all)
  );

  conv_group_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .INPUT_NUM_MEM(INPUT_NUM_MEM),
    .IFMAP_PAR    (IFMAP_PAR)
  ) u_mux_b (
    .group_sel(grp_cnt),
    .en       (in_run),
    .data_all (in_feature_q_b_all),
    .mux_all  (in_feature_q_b_mux_all)
  );

endmodule

// File: tb/tb_conv_layer_ctrl_gen.sv
// tb/tb_conv_layer_ctrl_gen.sv - directed self-checking bench for conv_layer_ctrl_gen
module tb_conv_layer_ctrl_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        abort = 1'b0;
  logic        stall = 1'b0;
  logic [79:0] q_a_all, q_b_all;
  logic [15:0] mux_a, mux_b;
  logic        mem_rden, enable_addrger, enable_mult, accum_sload, pix_done, busy, conv_done;
  logic [5:0]  count_sload;
  logic [2:0]  group_sel;

  logic [31:0] q_a_s, q_b_s, mux_a_s, mux_b_s;
  logic        mem_rden_s, enable_addrger_s, enable_mult_s, accum_sload_s, pix_done_s, busy_s, conv_done_s;
  logic [3:0]  count_sload_s;
  logic [0:0]  group_sel_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  conv_layer_ctrl_gen #(
    .DATA_WIDTH(8), .INPUT_NUM_MEM(10), .IFMAP_PAR(2), .CYC_PER_GROUP(9),
    .OUT_W(8), .OUT_H(8), .NUM_ONEMULT(1), .PIPE_DELAY(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall),
    .in_feature_q_a_all(q_a_all), .in_feature_q_b_all(q_b_all),
    .in_feature_q_a_mux_all(mux_a), .in_feature_q_b_mux_all(mux_b),
    .mem_rden(mem_rden), .enable_addrger(enable_addrger), .enable_mult(enable_mult),
    .accum_sload(accum_sload), .count_sload(count_sload), .group_sel(group_sel),
    .pix_done(pix_done), .busy(busy), .conv_done(conv_done)
  );

  conv_layer_ctrl_gen #(
    .DATA_WIDTH(8), .INPUT_NUM_MEM(4), .IFMAP_PAR(4), .CYC_PER_GROUP(9),
    .OUT_W(2), .OUT_H(2), .NUM_ONEMULT(1), .PIPE_DELAY(4)
  ) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start_s), .abort(abort), .stall(stall),
    .in_feature_q_a_all(q_a_s), .in_feature_q_b_all(q_b_s),
    .in_feature_q_a_mux_all(mux_a_s), .in_feature_q_b_mux_all(mux_b_s),
    .mem_rden(mem_rden_s), .enable_addrger(enable_addrger_s), .enable_mult(enable_mult_s),
    .accum_sload(accum_sload_s), .count_sload(count_sload_s), .group_sel(group_sel_s),
    .pix_done(pix_done_s), .busy(busy_s), .conv_done(conv_done_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, conv_done, mem_rden, enable_addrger, enable_mult, accum_sload, pix_done} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000",
        {busy, conv_done, mem_rden, enable_addrger, enable_mult, accum_sload, pix_done});
    end
    checks++;
    if (count_sload !== 6'd0 || group_sel !== 3'd0) begin
      errors++; $display("FAIL reset_counts got cnt=%0d grp=%0d exp 0/0", count_sload, group_sel);
    end
    checks++;
    if (mux_a !== 16'h0 || mux_b !== 16'h0) begin
      errors++; $display("FAIL reset_mux got %h/%h exp 0000/0000", mux_a, mux_b);
    end
    checks++;
    if (busy_s !== 1'b0 || mux_a_s !== 32'h0) begin
      errors++; $display("FAIL reset_small got busy=%b mux=%h exp 0/0", busy_s, mux_a_s);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_run();
    int run_cyc, drain_cyc, pix_cnt, g;
    logic seen;
    run_cyc = 0; drain_cyc = 0; pix_cnt = 0; seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_rden !== 1'b1 || enable_addrger !== 1'b1 || enable_mult !== 1'b0 ||
          accum_sload !== 1'b0 || mux_a !== 16'h0) begin
        errors++; $display("FAIL fill_cyc%0d got rden=%b mult=%b sload=%b mux=%h exp 1/0/0/0000",
          k, mem_rden, enable_mult, accum_sload, mux_a);
      end
      tick();
    end
    for (int c = 0; c < 45; c++) begin
      g = c / 9;
      checks++;
      if (count_sload !== 6'(c) || group_sel !== 3'(g)) begin
        errors++; $display("FAIL run_cnt c=%0d got cnt=%0d grp=%0d exp %0d/%0d", c, count_sload, group_sel, c, g);
      end
      checks++;
      if (accum_sload !== (c == 0) || pix_done !== (c == 44) || enable_mult !== 1'b1) begin
        errors++; $display("FAIL run_ctl c=%0d got sload=%b pix=%b mult=%b", c, accum_sload, pix_done, enable_mult);
      end
      checks++;
      if (mux_a !== {8'(2*g+2), 8'(2*g+1)} || mux_b !== {8'(8'h81+2*g), 8'(8'h80+2*g)}) begin
        errors++; $display("FAIL run_mux c=%0d got %h/%h exp %h/%h", c, mux_a, mux_b,
          {8'(2*g+2), 8'(2*g+1)}, {8'(8'h81+2*g), 8'(8'h80+2*g)});
      end
      if (pix_done) pix_cnt++;
      run_cyc++;
      tick();
    end
    for (int n = 0; n < 3000 && !seen; n++) begin
      if (conv_done) begin
        seen = 1'b1;
      end else begin
        if (mem_rden) begin
          run_cyc++;
        end else if (enable_mult) begin
          drain_cyc++;
          checks++;
          if (mux_a !== 16'h0) begin errors++; $display("FAIL drain_mux got %h exp 0000", mux_a); end
        end
        if (pix_done) pix_cnt++;
        tick();
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout got 0 exp 1"); end
    checks++;
    if (run_cyc != 2880 || drain_cyc != 4) begin
      errors++; $display("FAIL run_lengths got run=%0d drain=%0d exp 2880/4", run_cyc, drain_cyc);
    end
    checks++;
    if (pix_cnt != 64) begin errors++; $display("FAIL pix_count got %0d exp 64", pix_cnt); end
    tick();
    checks++;
    if (busy !== 1'b0 || conv_done !== 1'b0) begin
      errors++; $display("FAIL after_done got busy=%b done=%b exp 0/0", busy, conv_done);
    end
  endtask

  task automatic test_stall();
    int pix_cnt;
    logic found;
    pix_cnt = 0; found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      if (pix_cnt == 3 && count_sload == 6'd20 && mem_rden) found = 1'b1;
      else begin
        if (pix_done) pix_cnt++;
        tick();
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_reach got 0 exp 1"); end
    stall = 1'b1;
    #1;
    checks++;
    if (mem_rden !== 1'b0 || enable_addrger !== 1'b0 || enable_mult !== 1'b0) begin
      errors++; $display("FAIL stall_enables got %b%b%b exp 000", mem_rden, enable_addrger, enable_mult);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (count_sload !== 6'd20 || group_sel !== 3'd2 || enable_mult !== 1'b0 || mux_a !== 16'h0605) begin
        errors++; $display("FAIL stall_hold%0d got cnt=%0d grp=%0d mult=%b mux=%h exp 20/2/0/0605",
          k, count_sload, group_sel, enable_mult, mux_a);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (mem_rden !== 1'b1 || enable_mult !== 1'b1 || count_sload !== 6'd20) begin
      errors++; $display("FAIL stall_release got rden=%b mult=%b cnt=%0d exp 1/1/20", mem_rden, enable_mult, count_sload);
    end
    tick();
    checks++;
    if (count_sload !== 6'd21) begin errors++; $display("FAIL stall_resume got %0d exp 21", count_sload); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_cleanup got busy=%b exp 0", busy); end
  endtask

  task automatic test_abort();
    int pix_cnt, n, done_cnt;
    logic found;
    pix_cnt = 0; found = 1'b0; done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (pix_cnt == 10 && count_sload == 6'd5) found = 1'b1;
      else begin
        if (pix_done) pix_cnt++;
        tick();
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach got 0 exp 1"); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_rden !== 1'b0 || enable_mult !== 1'b0 || conv_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b rden=%b mult=%b done=%b exp 0000",
        busy, mem_rden, enable_mult, conv_done);
    end
    checks++;
    if (count_sload !== 6'd0 || group_sel !== 3'd0 || mux_a !== 16'h0) begin
      errors++; $display("FAIL abort_counts got cnt=%0d grp=%0d mux=%h exp 0/0/0000", count_sload, group_sel, mux_a);
    end
    for (int k = 0; k < 50; k++) begin
      if (conv_done || busy) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!conv_done && n < 3500) begin
      tick();
      n++;
    end
    checks++;
    if (conv_done !== 1'b1 || n != 2889) begin
      errors++; $display("FAIL restart_done got done=%b at %0d exp 1 at 2889", conv_done, n);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (accum_sload !== 1'b0 || mem_rden !== 1'b1 || enable_mult !== 1'b0) begin
      errors++; $display("FAIL restart_fill got sload=%b rden=%b mult=%b exp 0/1/0", accum_sload, mem_rden, enable_mult);
    end
    tick();
    checks++;
    if (accum_sload !== 1'b1 || count_sload !== 6'd0 || enable_mult !== 1'b1) begin
      errors++; $display("FAIL restart_run got sload=%b cnt=%0d mult=%b exp 1/0/1", accum_sload, count_sload, enable_mult);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count_sload !== 6'd2 || busy !== 1'b1 || mem_rden !== 1'b1) begin
      errors++; $display("FAIL start_in_run got cnt=%0d busy=%b rden=%b exp 2/1/1", count_sload, busy, mem_rden);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_rden !== 1'b0) begin
      errors++; $display("FAIL start_abort got busy=%b rden=%b exp 0/0", busy, mem_rden);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_hold got %b exp 0", busy); end
  endtask

  task automatic test_small_cfg();
    int n, pix_cnt, grp_bad, done_cnt;
    logic lane_seen;
    pix_cnt = 0; grp_bad = 0; done_cnt = 0; lane_seen = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 1;
    while (!conv_done_s && n < 200) begin
      if (pix_done_s) pix_cnt++;
      if (group_sel_s !== 1'b0) grp_bad++;
      if (accum_sload_s && !lane_seen) begin
        lane_seen = 1'b1;
        checks++;
        if (mux_a_s !== 32'h13121110 || mux_b_s !== 32'h23222120) begin
          errors++; $display("FAIL small_lanes got %h/%h exp 13121110/23222120", mux_a_s, mux_b_s);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (conv_done_s !== 1'b1 || n != 45) begin
      errors++; $display("FAIL small_done got done=%b at %0d exp 1 at 45", conv_done_s, n);
    end
    checks++;
    if (pix_cnt != 4 || grp_bad != 0) begin
      errors++; $display("FAIL small_pix got pix=%0d grp_nonzero=%0d exp 4/0", pix_cnt, grp_bad);
    end
    for (int k = 0; k < 10; k++) begin
      if (conv_done_s) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 1 || busy_s !== 1'b0) begin
      errors++; $display("FAIL small_once got pulses=%0d busy=%b exp 1/0", done_cnt, busy_s);
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      q_a_all[i*8 +: 8] = 8'(i + 1);
      q_b_all[i*8 +: 8] = 8'(8'h80 + i);
    end
    for (int i = 0; i < 4; i++) begin
      q_a_s[i*8 +: 8] = 8'(8'h10 + i);
      q_b_s[i*8 +: 8] = 8'(8'h20 + i);
    end
    test_reset();
    test_full_run();
    test_stall();
    test_abort();
    test_start_ignored();
    test_small_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
